// File: rtl/s_full_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : s_full_adder_pkg
// Description : Shared constants and helpers for the structural full-adder
//               slice. It holds the legal operand-width range and the carry
//               merge used by each ripple cell.
// Revision    : 1.0 - initial release
// ============================================================================
package s_full_adder_pkg;

    // Legal range for the ripple-carry operand width
    localparam int c_MIN_WIDTH = 1;
    localparam int c_MAX_WIDTH = 32;

    // Carry out of one full-adder cell: it is set when either half adder
    // generated a carry
    function automatic logic f_carry_merge(input logic i_g1, input logic i_g2);
        return i_g1 | i_g2;
    endfunction

endpackage : s_full_adder_pkg
`default_nettype wire

// File: rtl/s_half_adder.sv
`default_nettype none
// ============================================================================
// Module      : s_half_adder
// Description : Single-bit half adder cell (s = x ^ y, c = x & y). Purely
//               combinational; this is the leaf of the structural adder.
// Revision    : 1.0 - initial release
// ============================================================================
module s_half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    // Sum and carry of two single-bit operands
    always_comb begin
        s = x ^ y;
        c = x & y;
    end

endmodule : s_half_adder
`default_nettype wire

// File: rtl/s_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : s_full_adder
// Description : Structural ripple-carry adder. Each bit is built from two
//               half-adder cells plus an OR gate. Sum and carry-out are
//               registered, so results appear one clock after the operands
//               are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module s_full_adder
    import s_full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Per-bit half-adder outputs and the ripple carry chain.
    // w_c[0] is the external carry-in and w_c[WIDTH] is the final carry.
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g1;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_g2;
    logic [WIDTH:0]   w_c;

    // Output flops; these are the only state in the block
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    assign w_c[0] = cin;

    // One full-adder cell per bit: HA1 on the operands, HA2 on the
    // propagate term and the incoming carry, then OR the two generates
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        s_half_adder u_ha_ops (
            .x (a[gi]),
            .y (b[gi]),
            .s (w_p[gi]),
            .c (w_g1[gi])
        );

        s_half_adder u_ha_carry (
            .x (w_p[gi]),
            .y (w_c[gi]),
            .s (w_s[gi]),
            .c (w_g2[gi])
        );

        assign w_c[gi+1] = f_carry_merge(w_g1[gi], w_g2[gi]);
    end : g_bit

    // Register the result; reset wins over whatever was computed this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_s;
            r_cout <= w_c[WIDTH];
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule : s_full_adder
`default_nettype wire

// File: tb/tb_s_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_s_full_adder
// Description : Self-checking bench for s_full_adder. It drives a 1-bit and a
//               4-bit instance and checks both against a + b + cin from the
//               previous cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s_full_adder;

    logic       clk;
    logic       rst;
    logic [0:0] a1, b1;
    logic       cin1;
    logic [0:0] sum1;
    logic       cout1;
    logic [3:0] a4, b4;
    logic       cin4;
    logic [3:0] sum4;
    logic       cout4;

    int n_checks = 0;
    int n_pass   = 0;

    s_full_adder #(.WIDTH(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .a    (a1),
        .b    (b1),
        .cin  (cin1),
        .sum  (sum1),
        .cout (cout1)
    );

    s_full_adder #(.WIDTH(4)) u_dut4 (
        .clk  (clk),
        .rst  (rst),
        .a    (a4),
        .b    (b4),
        .cin  (cin4),
        .sum  (sum4),
        .cout (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the full-width sum of the operands
    function automatic logic [1:0] ref1(input logic a, input logic b, input logic c);
        return 2'(a) + 2'(b) + 2'(c);
    endfunction

    function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic c);
        return 5'(a) + 5'(b) + 5'(c);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        a4 = 4'h1; b4 = 4'h1; cin4 = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({cout1, sum1} !== 2'b00)
            $display("FAIL reset_w1: got cout/sum=%b/%b want 0/0", cout1, sum1);
        else n_pass++;
        n_checks++;
        if ({cout4, sum4} !== 5'h00)
            $display("FAIL reset_w4: got cout/sum=%b/%h want 0/0", cout4, sum4);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if ({cout1, sum1} !== 2'b11)
            $display("FAIL reset_release_w1: got cout/sum=%b/%b want 1/1", cout1, sum1);
        else n_pass++;
        n_checks++;
        if ({cout4, sum4} !== 5'h03)
            $display("FAIL reset_release_w4: got cout/sum=%b/%h want 0/3", cout4, sum4);
        else n_pass++;
    endtask

    task automatic test_truth_table();
        // Results written as {cout, sum} for inputs a,b,cin = 000..111
        logic [1:0] table_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10,
                                      2'b01, 2'b10, 2'b10, 2'b11};
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vec;
            vec  = 3'(v);
            a1   = vec[2];
            b1   = vec[1];
            cin1 = vec[0];
            tick();
            n_checks++;
            if ({cout1, sum1} !== table_exp[v] || table_exp[v] !== ref1(vec[2], vec[1], vec[0]))
                $display("FAIL truth_%0d%0d%0d: got cout/sum=%b/%b want %b/%b",
                         vec[2], vec[1], vec[0], cout1, sum1, table_exp[v][1], table_exp[v][0]);
            else n_pass++;
        end
    endtask

    task automatic test_latency();
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        tick();
        // Inputs change right after edge N; registered value must not move yet
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
        #1;
        n_checks++;
        if ({cout1, sum1} !== 2'b00)
            $display("FAIL latency_hold: got cout/sum=%b/%b want 0/0", cout1, sum1);
        else n_pass++;
        tick();
        n_checks++;
        if ({cout1, sum1} !== 2'b10)
            $display("FAIL latency_update: got cout/sum=%b/%b want 1/0", cout1, sum1);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1;
        a4 = 4'hA; b4 = 4'h9; cin4 = 1'b1;
        tick();
        n_checks++;
        if ({cout1, sum1} !== 2'b10)
            $display("FAIL midrst_pre: got cout/sum=%b/%b want 1/0", cout1, sum1);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({cout1, sum1} !== 2'b00)
            $display("FAIL midrst_w1: got cout/sum=%b/%b want 0/0", cout1, sum1);
        else n_pass++;
        n_checks++;
        if ({cout4, sum4} !== 5'h00)
            $display("FAIL midrst_w4: got cout/sum=%b/%h want 0/0", cout4, sum4);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if ({cout1, sum1} !== 2'b10)
            $display("FAIL midrst_post: got cout/sum=%b/%b want 1/0", cout1, sum1);
        else n_pass++;
        n_checks++;
        if ({cout4, sum4} !== ref4(4'hA, 4'h9, 1'b1))
            $display("FAIL midrst_post_w4: got cout/sum=%b/%h want 1/4", cout4, sum4);
        else n_pass++;
    endtask

    task automatic test_ripple4();
        a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
        tick();
        n_checks++;
        if (cout4 !== 1'b1 || sum4 !== 4'h0)
            $display("FAIL ripple_full: got cout/sum=%b/%h want 1/0", cout4, sum4);
        else n_pass++;
        a4 = 4'h7; b4 = 4'h8; cin4 = 1'b0;
        tick();
        n_checks++;
        if (cout4 !== 1'b0 || sum4 !== 4'hF)
            $display("FAIL ripple_nocarry: got cout/sum=%b/%h want 0/f", cout4, sum4);
        else n_pass++;
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        tick();
        n_checks++;
        if (cout4 !== 1'b1 || sum4 !== 4'hF)
            $display("FAIL ripple_allones: got cout/sum=%b/%h want 1/f", cout4, sum4);
        else n_pass++;
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 200; i++) begin
            logic [4:0] exp4;
            logic [1:0] exp1;
            a4   = 4'($urandom);
            b4   = 4'($urandom);
            cin4 = 1'($urandom);
            a1   = 1'($urandom);
            b1   = 1'($urandom);
            cin1 = 1'($urandom);
            exp4 = ref4(a4, b4, cin4);
            exp1 = ref1(a1, b1, cin1);
            tick();
            n_checks++;
            if ({cout4, sum4} !== exp4)
                $display("FAIL random_w4[%0d]: got cout/sum=%b/%h want %b/%h",
                         i, cout4, sum4, exp4[4], exp4[3:0]);
            else n_pass++;
            n_checks++;
            if ({cout1, sum1} !== exp1)
                $display("FAIL random_w1[%0d]: got cout/sum=%b/%b want %b/%b",
                         i, cout1, sum1, exp1[1], exp1[0]);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        a1 = '0; b1 = '0; cin1 = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0;
        test_reset();
        test_truth_table();
        test_latency();
        test_reset_mid();
        test_ripple4();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_s_full_adder
`default_nettype wire
